load_align_unit: RTL and testbench

- Load-side counterpart of the store alignment path. Accepts one load request, reads the 32-bit data memory through its 16-bit byte address, then extracts the addressed byte, halfword or word with sign or zero extension.
- Completes misaligned (cross-word) halfword and word loads with two sequential word reads and a merge.
- Sits between the MEM stage and the data SRAM read port.

---
 rtl/load_align_unit.sv | 153 +++++++++++++++
 tb/tb_load_align_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// load_align_unit: load-side alignment path between the MEM stage and the
// data SRAM read port. Reads one or two 32-bit words for a byte, halfword or
// word load, merges them for cross-word accesses and sign/zero-extends the
// addressed field into a registered result.

`ifndef MEM_READ
`define MEM_READ  2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif
`ifndef MEM_BYTE
`define MEM_BYTE  2'b00
`endif
`ifndef MEM_HALF
`define MEM_HALF  2'b01
`endif
`ifndef MEM_WORD
`define MEM_WORD  2'b10
`endif

module load_align_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        mem_op,
    input  logic [31:0]       addr,
    output logic [ADDR_W-1:0] addrin,
    output logic              rd_en,
    input  logic [31:0]       dataout,
    output logic [31:0]       load_data,
    output logic              load_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR0,
        S_DATA0,
        S_ADDR1,
        S_DATA1,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [1:0]          off_q, off_d;
    logic [ADDR_W-1:0]   addrin_q, addrin_d;
    logic [31:0]         word0_q, word0_d;
    logic [31:0]         load_data_q, load_data_d;

    // Upper address bits beyond the SRAM range are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W];

    // A halfword at lane 3, or any word not on lane 0, spills into the next word.
    function automatic logic is_cross(input logic [1:0] size, input logic [1:0] off);
        return ((size == `MEM_HALF) && (off == 2'd3)) ||
               ((size == `MEM_WORD) && (off != 2'd0));
    endfunction

    // Shift the little-endian word pair down by the byte offset, then extend.
    function automatic logic [31:0] extract(input logic [1:0]  size,
                                            input logic        uns,
                                            input logic [1:0]  off,
                                            input logic [31:0] w0,
                                            input logic [31:0] w1);
        logic [63:0] shifted;
        logic [31:0] lo;
        shifted = {w1, w0} >> {off, 3'b000};
        lo      = shifted[31:0];
        case (size)
            `MEM_BYTE: extract = uns ? {24'h0, lo[7:0]}  : {{24{lo[7]}},  lo[7:0]};
            `MEM_HALF: extract = uns ? {16'h0, lo[15:0]} : {{16{lo[15]}}, lo[15:0]};
            `MEM_WORD: extract = lo;
            default:   extract = 32'h0;
        endcase
    endfunction

    // Next-state and datapath decode for the load sequencer.
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        addrin_d    = addrin_q;
        word0_d     = word0_q;
        load_data_d = load_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && (mem_op[4:3] == `MEM_READ)) begin
                    size_d   = mem_op[1:0];
                    uns_d    = mem_op[2];
                    off_d    = addr[1:0];
                    addrin_d = {addr[ADDR_W-1:2], 2'b00};
                    state_d  = S_ADDR0;
                end
            end
            S_ADDR0: state_d = S_DATA0;
            S_DATA0: begin
                word0_d = dataout;
                if (is_cross(size_q, off_q)) begin
                    addrin_d = addrin_q + ADDR_W'(4);
                    state_d  = S_ADDR1;
                end else begin
                    load_data_d = extract(size_q, uns_q, off_q, dataout, 32'h0);
                    state_d     = S_RESP;
                end
            end
            S_ADDR1: state_d = S_DATA1;
            S_DATA1: begin
                load_data_d = extract(size_q, uns_q, off_q, word0_q, dataout);
                state_d     = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-request registers; reset aborts any access in flight.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            addrin_q    <= '0;
            word0_q     <= 32'h0;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            addrin_q    <= addrin_d;
            word0_q     <= word0_d;
            load_data_q <= load_data_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign rd_en      = (state_q == S_ADDR0) || (state_q == S_ADDR1);
    assign load_valid = (state_q == S_RESP);
    assign addrin     = addrin_q;
    assign load_data  = load_data_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: byte-level reference model with a
// per-cycle compare process, plus literal expectations for each load.

`ifndef MEM_READ
`define MEM_READ  2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif

module tb_load_align_unit;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [4:0]        mem_op = 5'h0;
    logic [31:0]       addr = 32'h0;
    logic [ADDR_W-1:0] addrin;
    logic              rd_en;
    logic [31:0]       dataout = 32'h0;
    logic [31:0]       load_data;
    logic              load_valid;

    load_align_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_op     (mem_op),
        .addr       (addr),
        .addrin     (addrin),
        .rd_en      (rd_en),
        .dataout    (dataout),
        .load_data  (load_data),
        .load_valid (load_valid)
    );

    always #5 clk = ~clk;

    // Op encodings: {type, unsigned, size}
    localparam logic [4:0] OP_LB  = {`MEM_READ, 1'b0, 2'b00};
    localparam logic [4:0] OP_LBU = {`MEM_READ, 1'b1, 2'b00};
    localparam logic [4:0] OP_LH  = {`MEM_READ, 1'b0, 2'b01};
    localparam logic [4:0] OP_LHU = {`MEM_READ, 1'b1, 2'b01};
    localparam logic [4:0] OP_LW  = {`MEM_READ, 1'b0, 2'b10};
    localparam logic [4:0] OP_LR  = {`MEM_READ, 1'b0, 2'b11};
    localparam logic [4:0] OP_SW  = {`MEM_WRITE, 1'b0, 2'b10};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM contents
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0010: return 32'h8899AABB;
            16'h0014: return 32'h11223344;
            16'hFFFC: return 32'hDDCCBBAA;
            16'h0000: return 32'h76543210;
            default:  return {16'hA5A5, a};
        endcase
    endfunction

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        logic [31:0] w;
        w = mem_word({a[15:2], 2'b00}) >> (8 * int'(a[1:0]));
        return w[7:0];
    endfunction

    // Reference: gather n bytes little-endian from a (16-bit wrap), then extend.
    function automatic logic [31:0] model_load(input logic [4:0] op, input logic [15:0] a);
        int n;
        logic [31:0] v;
        v = 32'h0;
        case (op[1:0])
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b10:   n = 4;
            default: return 32'h0;
        endcase
        for (int i = 0; i < n; i++)
            v = v | (32'(mem_byte(a + 16'(i))) << (8 * i));
        if (n == 4 || op[2]) return v;
        if (n == 1) return {{24{v[7]}}, v[7:0]};
        return {{16{v[15]}}, v[15:0]};
    endfunction

    function automatic bit model_cross(input logic [4:0] op, input logic [1:0] off);
        case (op[1:0])
            2'b01:   return off == 2'd3;
            2'b10:   return off != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    // SRAM read port: one-cycle read latency
    initial forever begin
        @(posedge clk);
        if (rd_en) dataout <= mem_word(addrin);
    end

    // Model timeline: cycle index advances per edge; accept/read/response cycles
    int          cyc      = 0;
    int          acc_cyc  = -100;
    int          resp_cyc = -100;
    bit          cross_m  = 1'b0;
    logic [15:0] a0_m     = 16'h0;
    logic [15:0] a1_m     = 16'h0;
    logic [31:0] pend_m   = 32'h0;
    logic [31:0] held_m   = 32'h0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            acc_cyc  = -100;
            resp_cyc = -100;
            held_m   = 32'h0;
        end else begin
            cyc = cyc + 1;
            if (cyc == resp_cyc) held_m = pend_m;
            if (cyc - 1 > resp_cyc && req_valid && mem_op[4:3] == `MEM_READ) begin
                cross_m  = model_cross(mem_op, addr[1:0]);
                acc_cyc  = cyc;
                resp_cyc = cyc + (cross_m ? 4 : 2);
                a0_m     = {addr[15:2], 2'b00};
                a1_m     = a0_m + 16'd4;
                pend_m   = model_load(mem_op, addr[15:0]);
            end
        end
    end

    // Per-cycle compare against the model, mid-cycle
    initial forever begin
        @(negedge clk);
        check("req_ready", {31'b0, req_ready},
              {31'b0, !(cyc >= acc_cyc && cyc <= resp_cyc)});
        check("rd_en", {31'b0, rd_en},
              {31'b0, (cyc == acc_cyc) || (cross_m && cyc == acc_cyc + 2)});
        if (cyc == acc_cyc)
            check("addrin0", {16'b0, addrin}, {16'b0, a0_m});
        if (cross_m && cyc == acc_cyc + 2)
            check("addrin1", {16'b0, addrin}, {16'b0, a1_m});
        check("load_valid", {31'b0, load_valid}, {31'b0, cyc == resp_cyc});
        check("load_data", load_data, held_m);
    end

    // Event counters for literal checks
    int          rd_total    = 0;
    int          valid_total = 0;
    logic [15:0] last_rd_a   = 16'h0;
    initial forever begin
        @(negedge clk);
        if (rd_en) begin
            rd_total++;
            last_rd_a = addrin;
        end
        if (load_valid) valid_total++;
    end

    task automatic do_load(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] exp, input int exp_rd, input int exp_lat);
        int r0;
        int n;
        bit got;
        @(negedge clk);
        req_valid = 1'b1;
        mem_op    = op;
        addr      = a;
        r0        = rd_total;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            n++;
            if (load_valid) got = 1'b1;
        end
        check({name, "_seen"}, {31'b0, got}, 32'd1);
        check({name, "_data"}, load_data, exp);
        check({name, "_lat"}, n, exp_lat);
        check({name, "_rdcnt"}, rd_total - r0, exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        int v0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rd_en", {31'b0, rd_en}, 32'd0);
        check("rst_valid", {31'b0, load_valid}, 32'd0);
        check("rst_data", load_data, 32'h0);
        check("rst_addrin", {16'b0, addrin}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Aligned loads
        do_load("lb_11",  OP_LB,  32'h0011, 32'hFFFFFFAA, 1, 3);
        do_load("lbu_11", OP_LBU, 32'h0011, 32'h000000AA, 1, 3);
        do_load("lb_13",  OP_LB,  32'h0013, 32'hFFFFFF88, 1, 3);
        do_load("lbu_14", OP_LBU, 32'h0014, 32'h00000044, 1, 3);
        do_load("lh_12",  OP_LH,  32'h0012, 32'hFFFF8899, 1, 3);
        do_load("lhu_12", OP_LHU, 32'h0012, 32'h00008899, 1, 3);
        do_load("lh_10",  OP_LH,  32'h0010, 32'hFFFFAABB, 1, 3);
        do_load("lw_10",  OP_LW,  32'h0010, 32'h8899AABB, 1, 3);
        do_load("rsv_13", OP_LR,  32'h0013, 32'h00000000, 1, 3);

        // Cross-word loads
        do_load("lh_13",  OP_LH,  32'h0013, 32'h00004488, 2, 5);
        check("lh_13_a1", {16'b0, last_rd_a}, 32'h0014);
        do_load("lw_11",  OP_LW,  32'h0011, 32'h448899AA, 2, 5);
        do_load("lw_13",  OP_LW,  32'h0013, 32'h22334488, 2, 5);
        do_load("lw_fffe", OP_LW, 32'hFFFE, 32'h3210DDCC, 2, 5);
        check("lw_fffe_wrap", {16'b0, last_rd_a}, 32'h0000);
        do_load("lhu_ffff", OP_LHU, 32'hFFFF, 32'h000010DD, 2, 5);

        // Result holds between responses
        repeat (3) @(negedge clk);
        check("hold_data", load_data, 32'h000010DD);

        // Write op is ignored
        r0 = rd_total;
        v0 = valid_total;
        @(negedge clk);
        req_valid = 1'b1;
        mem_op    = OP_SW;
        addr      = 32'h0010;
        repeat (6) @(negedge clk);
        check("wr_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("wr_no_rd", rd_total - r0, 0);
        check("wr_no_valid", valid_total - v0, 0);

        // Read held across a busy period: second accept only after RESP->IDLE
        r0 = rd_total;
        v0 = valid_total;
        @(negedge clk);
        req_valid = 1'b1;
        mem_op    = OP_LB;
        addr      = 32'h0010;
        repeat (5) @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("held_rdcnt", rd_total - r0, 2);
        check("held_vcnt", valid_total - v0, 2);
        check("held_data", load_data, 32'hFFFFFFBB);

        // Reset during DATA0 of a cross-word LW
        @(negedge clk);
        req_valid = 1'b1;
        mem_op    = OP_LW;
        addr      = 32'h0011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", {31'b0, rd_en}, 32'd0);
        check("mid_rst_valid", {31'b0, load_valid}, 32'd0);
        check("mid_rst_data", load_data, 32'h0);
        check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        r0 = rd_total;
        v0 = valid_total;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_no_rd", rd_total - r0, 0);
        check("post_rst_no_valid", valid_total - v0, 0);
        do_load("lb_10", OP_LB, 32'h0010, 32'hFFFFFFBB, 1, 3);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
